default_add_pipe: RTL and testbench
===================================

# default_add_pipe

Multi-lane pipelined adder in which each lane's second operand falls back to a compile-time default when the caller does not supply one. It generalises a fixed `a + b (b defaults to 10)` expression to LANES lanes of WIDTH bits, with three modes: plain add, saturating add and per-lane running accumulate. Results leave through a valid/ready stream after a parametrised latency. It sits in the datapath as a reusable arithmetic stage between stream producers and consumers.

## Interface
- WIDTH, 8, operand width per lane.
- LANES, 4, number of independent lanes.
- DEFAULT_B, 10, value used for b on any lane whose b_en bit is 0. Elaboration error if DEFAULT_B > 2^WIDTH-1.
- STAGES, 2, pipeline depth (1..4). Elaboration error outside this range.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  LANES*WIDTH  operand a; lane i is bits [i*WIDTH +: WIDTH].
- b  in  LANES*WIDTH  operand b, same packing.
- b_en  in  LANES  per lane: 1 = use b, 0 = use DEFAULT_B.
- mode  in  2  per-beat mode: 0 ADD, 1 SAT, 2 ACC, 3 reserved (behaves as ADD).
- acc_clr  in  1  clears all lane accumulators.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the beat.
- sum  out  LANES*(WIDTH+1)  per-lane result; lane i is bits [i*(WIDTH+1) +: WIDTH+1].
- ovf  out  LANES  per-lane clip flag for this beat.

## Operation
- b_eff[i] = b_en[i] ? b[i] : DEFAULT_B. All arithmetic is unsigned.
- ADD mode:
  - sum = a + b_eff, full WIDTH+1 bits; it cannot overflow.
  - ovf = 0.
- SAT mode:
  - s = a + b_eff.
  - If s > 2^WIDTH-1: sum = 2^WIDTH-1 and ovf = 1.
  - Otherwise sum = s and ovf = 0.
  - sum[WIDTH] is always 0.
- ACC mode:
  - acc[i] = acc[i] + a + b_eff, saturating at 2^(WIDTH+1)-1.
  - sum = the new acc value.
  - ovf = 1 if this beat clipped.
  - The accumulator updates only on an accepted ACC beat. ADD and SAT beats leave acc untouched.
- acc_clr:
  - With no accepted ACC beat in the same cycle: acc = 0 at the next edge, whether or not the pipeline is stalled.
  - With an accepted ACC beat in the same cycle: clear first, then add, so acc = a + b_eff.
- Beat acceptance: a beat is accepted when in_valid && in_ready.
- Pipeline control:
  - en = !out_valid || out_ready.
  - in_ready = en (combinational).
  - All stages advance together when en = 1. Bubbles are not collapsed.
- Ordering: beats leave in arrival order. No beat is dropped or duplicated.

## Timing
- Reset (asynchronous, takes effect immediately):
  - out_valid = 0, sum = 0, ovf = 0.
  - All stage valids = 0, all acc = 0.
  - in_ready = 1 while rst_n is high and the pipeline is idle.
- Latency: a beat accepted at edge k appears with out_valid = 1 after edge k+STAGES-1. With STAGES = 1, the result is visible in the cycle after acceptance.
- Throughput: 1 beat per cycle while out_ready = 1.
- Stall behaviour: while out_valid && !out_ready:
  - sum, ovf and out_valid hold stable.
  - in_ready = 0.
  - Accumulators change only through acc_clr.
- Compute placement: all arithmetic happens in stage 1. Stages 2..STAGES are pure delay registers.
- Reset mid-operation: all in-flight beats are discarded and acc returns to 0. The first beat after deassertion behaves as after power-up.

## Structure
- Package default_add_pkg holds:
  - typedef enum logic [1:0] mode_e {MODE_ADD, MODE_SAT, MODE_ACC, MODE_RSVD}.
  - Width helper functions.
- Sub-module default_add_lane, generated LANES times:
  - Performs b_eff selection, add/saturate and the accumulator register.
  - Produces stage-1 sum and ovf.
- Top level holds:
  - Stage valid bits, stall enable and the delay stages.
  - Lane packing and unpacking.

## Test plan
Defaults: WIDTH=8, LANES=4, DEFAULT_B=10, STAGES=2.
- Default operand, ADD: lane0 a=28, b_en=0; lane1 a=32, b=78, b_en=1 -> after 2 cycles, sum lane0 = 38, lane1 = 110, ovf = 0.
- ADD vs SAT: a=200, b=100, b_en=1 -> ADD gives 300 with ovf=0; SAT gives 255 with ovf=1. SAT a=250, b_en=0 -> 255, ovf=1.
- Accumulate: acc_clr pulse, then three ACC beats a=5, b_en=0 -> sums 15, 30, 45. Next beat with acc_clr=1, a=1 -> 11.
- ACC saturation: repeated ACC beats a=255, b=255 -> outputs 510, then 511 with ovf=1, then stays at 511.
- Backpressure: 4 back-to-back beats, out_ready low 3 cycles mid-stream -> in_ready low, sum stable, all 4 results delivered in order exactly once.
- Reset mid-stream: assert rst_n low while out_valid=1 with acc=30 -> out_valid drops immediately. After release, ACC a=5 -> 15.

Source files
------------

// File: rtl/default_add_pkg.sv
// Shared types and width helpers for the default-operand adder pipeline.
package default_add_pkg;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'd0,
        MODE_SAT  = 2'd1,
        MODE_ACC  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    function automatic int sum_width(input int width);
        return width + 1;
    endfunction

    function automatic longint max_unsigned(input int width);
        return (longint'(1) << width) - 1;
    endfunction

endpackage

// File: rtl/default_add_pipe_if.sv
// Input beat and result stream of the default-operand adder pipeline.
interface default_add_pipe_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
);
    import default_add_pkg::*;

    logic                                in_valid;
    logic                                in_ready;
    logic [LANES*WIDTH-1:0]              a;
    logic [LANES*WIDTH-1:0]              b;
    logic [LANES-1:0]                    b_en;
    logic [1:0]                          mode;
    logic                                acc_clr;
    logic                                out_valid;
    logic                                out_ready;
    logic [LANES*sum_width(WIDTH)-1:0]   sum;
    logic [LANES-1:0]                    ovf;

    modport master (
        output in_valid, a, b, b_en, mode, acc_clr, out_ready,
        input  in_ready, out_valid, sum, ovf
    );

    modport slave (
        input  in_valid, a, b, b_en, mode, acc_clr, out_ready,
        output in_ready, out_valid, sum, ovf
    );

endinterface

// File: rtl/default_add_lane.sv
// One lane: operand defaulting, add / saturate / accumulate, and the lane accumulator.
module default_add_lane
    import default_add_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEFAULT_B = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_en,
    input  mode_e            mode,
    input  logic             acc_clr,
    input  logic             accept,
    output logic [WIDTH:0]   sum,
    output logic             ovf
);

    localparam logic [WIDTH:0] SAT_MAX = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0] ACC_MAX = '1;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   raw;
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   acc_base;
    logic [WIDTH+1:0] acc_full;
    logic             acc_clip;
    logic [WIDTH:0]   acc_next;

    assign b_eff    = b_en ? b : WIDTH'(DEFAULT_B);
    assign raw      = {1'b0, a} + {1'b0, b_eff};
    // A same-cycle clear wins over the stored value, so clear-then-add falls out naturally.
    assign acc_base = acc_clr ? '0 : acc;
    assign acc_full = {1'b0, acc_base} + {1'b0, raw};
    assign acc_clip = acc_full[WIDTH+1];
    assign acc_next = acc_clip ? ACC_MAX : acc_full[WIDTH:0];

    always_comb begin
        sum = raw;
        ovf = 1'b0;
        case (mode)
            MODE_SAT: begin
                if (raw[WIDTH]) begin
                    sum = SAT_MAX;
                    ovf = 1'b1;
                end
            end
            MODE_ACC: begin
                sum = acc_next;
                ovf = acc_clip;
            end
            default: begin
                sum = raw;
                ovf = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (accept && mode == MODE_ACC) begin
            acc <= acc_next;
        end else if (acc_clr) begin
            acc <= '0;
        end
    end

endmodule

// File: rtl/default_add_pipe.sv
// Multi-lane pipelined adder with per-lane default operand; all stages stall together.
module default_add_pipe
    import default_add_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LANES     = 4,
    parameter int DEFAULT_B = 10,
    parameter int STAGES    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    default_add_pipe_if.slave bus
);

    localparam int SW = sum_width(WIDTH);

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("default_add_pipe: STAGES must be in 1..4");
    end
    if (longint'(DEFAULT_B) > max_unsigned(WIDTH) || DEFAULT_B < 0) begin : g_bad_default
        $error("default_add_pipe: DEFAULT_B does not fit in WIDTH bits");
    end

    logic                    en;
    logic                    accept;
    mode_e                   beat_mode;
    logic [LANES*SW-1:0]     s1_sum;
    logic [LANES-1:0]        s1_ovf;
    logic [LANES*SW-1:0]     pipe_sum [STAGES];
    logic [LANES-1:0]        pipe_ovf [STAGES];
    logic [STAGES-1:0]       pipe_vld;

    assign en           = !pipe_vld[STAGES-1] || bus.out_ready;
    assign accept       = bus.in_valid && en;
    assign beat_mode    = mode_e'(bus.mode);
    assign bus.in_ready = en;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        default_add_lane #(
            .WIDTH     (WIDTH),
            .DEFAULT_B (DEFAULT_B)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .a       (bus.a[i*WIDTH +: WIDTH]),
            .b       (bus.b[i*WIDTH +: WIDTH]),
            .b_en    (bus.b_en[i]),
            .mode    (beat_mode),
            .acc_clr (bus.acc_clr),
            .accept  (accept),
            .sum     (s1_sum[i*SW +: SW]),
            .ovf     (s1_ovf[i])
        );
    end

    // Stage 0 captures the lane results; later stages only delay them, bubbles included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int s = 0; s < STAGES; s++) begin
                pipe_sum[s] <= '0;
                pipe_ovf[s] <= '0;
            end
        end else if (en) begin
            pipe_vld[0] <= bus.in_valid;
            pipe_sum[0] <= s1_sum;
            pipe_ovf[0] <= s1_ovf;
            for (int s = 1; s < STAGES; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                pipe_sum[s] <= pipe_sum[s-1];
                pipe_ovf[s] <= pipe_ovf[s-1];
            end
        end
    end

    assign bus.out_valid = pipe_vld[STAGES-1];
    assign bus.sum       = pipe_sum[STAGES-1];
    assign bus.ovf       = pipe_ovf[STAGES-1];

endmodule

// File: tb/tb_default_add_pipe.sv
// Directed bench for default_add_pipe: reference model feeds a scoreboard checked at the output.
module tb_default_add_pipe;
    import default_add_pkg::*;

    localparam int W       = 8;
    localparam int L       = 4;
    localparam int DB      = 10;
    localparam int ST      = 2;
    localparam int SAT_LIM = (1 << W) - 1;
    localparam int ACC_LIM = (1 << (W + 1)) - 1;

    typedef struct {
        logic [L*(W+1)-1:0] sum;
        logic [L-1:0]       ovf;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   acc_m[L];

    default_add_pipe_if #(.WIDTH(W), .LANES(L)) bus ();

    default_add_pipe #(
        .WIDTH     (W),
        .LANES     (L),
        .DEFAULT_B (DB),
        .STAGES    (ST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [L*W-1:0] lanes4(input int v0, input int v1, input int v2, input int v3);
        return {W'(v3), W'(v2), W'(v1), W'(v0)};
    endfunction

    // Reference behaviour of one accepted beat, evaluated in plain integers.
    task automatic model_accept(input logic [L*W-1:0] a_v, input logic [L*W-1:0] b_v,
                                input logic [L-1:0] ben, input logic [1:0] md, input logic clr);
        exp_t e;
        e.sum = '0;
        e.ovf = '0;
        for (int i = 0; i < L; i++) begin
            int av, bv, s, res, base;
            logic flag;
            av   = int'(a_v[i*W +: W]);
            bv   = ben[i] ? int'(b_v[i*W +: W]) : DB;
            s    = av + bv;
            res  = s;
            flag = 1'b0;
            if (md == 2'd1) begin
                if (s > SAT_LIM) begin
                    res  = SAT_LIM;
                    flag = 1'b1;
                end
            end else if (md == 2'd2) begin
                base = clr ? 0 : acc_m[i];
                res  = base + s;
                if (res > ACC_LIM) begin
                    res  = ACC_LIM;
                    flag = 1'b1;
                end
                acc_m[i] = res;
            end
            if (clr && md != 2'd2) acc_m[i] = 0;
            e.sum[i*(W+1) +: W+1] = (W+1)'(res);
            e.ovf[i]              = flag;
        end
        sb.push_back(e);
    endtask

    task automatic apply_stimulus(input logic [L*W-1:0] a_v, input logic [L*W-1:0] b_v,
                                  input logic [L-1:0] ben, input logic [1:0] md, input logic clr);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.a        = a_v;
        bus.b        = b_v;
        bus.b_en     = ben;
        bus.mode     = md;
        bus.acc_clr  = clr;
        @(negedge clk);
        while (!bus.in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) check_output("accept_timeout", 64'(bus.in_ready), 64'd1);
        else model_accept(a_v, b_v, ben, md, clr);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.acc_clr  = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.in_valid = 1'b0;
        bus.acc_clr  = 1'b1;
        @(posedge clk);
        #1;
        bus.acc_clr = 1'b0;
        for (int i = 0; i < L; i++) acc_m[i] = 0;
    endtask

    // Output side of the scoreboard: every handshaken beat must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check_output("unexpected_beat", 64'(bus.out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                check_output("sum", 64'(bus.sum), 64'(e.sum));
                check_output("ovf", 64'(bus.ovf), 64'(e.ovf));
            end
        end
    end

    initial begin
        logic [L*(W+1)-1:0] held;
        for (int i = 0; i < L; i++) acc_m[i] = 0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.b_en      = '0;
        bus.mode      = 2'd0;
        bus.acc_clr   = 1'b0;
        bus.out_ready = 1'b1;

        $display("[TB] reset");
        repeat (2) @(negedge clk);
        check_output("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_output("rst_sum", 64'(bus.sum), 64'd0);
        check_output("rst_ovf", 64'(bus.ovf), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("idle_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        $display("[TB] default operand and latency");
        apply_stimulus(lanes4(28, 32, 0, 0), lanes4(0, 78, 0, 0), 4'b0010, 2'd0, 1'b0);
        @(negedge clk);
        check_output("latency_early", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check_output("latency_ontime", 64'(bus.out_valid), 64'd1);
        check_output("lane0_default", 64'(bus.sum[8:0]), 64'd38);
        check_output("lane1_explicit", 64'(bus.sum[17:9]), 64'd110);
        @(posedge clk);
        #1;

        $display("[TB] add versus saturate");
        apply_stimulus(lanes4(200, 200, 0, 255), lanes4(100, 55, 0, 255), 4'b1111, 2'd0, 1'b0);
        apply_stimulus(lanes4(200, 200, 0, 255), lanes4(100, 55, 0, 255), 4'b1111, 2'd1, 1'b0);
        apply_stimulus(lanes4(250, 245, 246, 0), lanes4(0, 0, 0, 0), 4'b0000, 2'd1, 1'b0);
        apply_stimulus(lanes4(1, 2, 3, 4), lanes4(2, 3, 4, 5), 4'b0101, 2'd3, 1'b0);

        $display("[TB] accumulate");
        pulse_clear();
        apply_stimulus(lanes4(5, 5, 5, 5), lanes4(0, 0, 0, 0), 4'b0000, 2'd2, 1'b0);
        apply_stimulus(lanes4(5, 5, 5, 5), lanes4(0, 0, 0, 0), 4'b0000, 2'd2, 1'b0);
        apply_stimulus(lanes4(5, 5, 5, 5), lanes4(0, 0, 0, 0), 4'b0000, 2'd2, 1'b0);
        apply_stimulus(lanes4(1, 1, 1, 1), lanes4(0, 0, 0, 0), 4'b0000, 2'd2, 1'b1);

        $display("[TB] accumulate saturation");
        pulse_clear();
        for (int n = 0; n < 3; n++)
            apply_stimulus(lanes4(255, 255, 255, 255), lanes4(255, 255, 255, 255), 4'b1111, 2'd2, 1'b0);

        $display("[TB] backpressure");
        apply_stimulus(lanes4(1, 2, 3, 4), lanes4(10, 20, 30, 40), 4'b1111, 2'd0, 1'b0);
        apply_stimulus(lanes4(5, 6, 7, 8), lanes4(10, 20, 30, 40), 4'b1111, 2'd0, 1'b0);
        bus.in_valid  = 1'b1;
        bus.a         = lanes4(9, 10, 11, 12);
        bus.out_ready = 1'b0;
        @(negedge clk);
        held = bus.sum;
        check_output("stall_in_ready", 64'(bus.in_ready), 64'd0);
        repeat (2) begin
            @(negedge clk);
            check_output("stall_in_ready", 64'(bus.in_ready), 64'd0);
            check_output("stall_valid", 64'(bus.out_valid), 64'd1);
            check_output("stall_sum_stable", 64'(bus.sum), 64'(held));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        apply_stimulus(lanes4(9, 10, 11, 12), lanes4(10, 20, 30, 40), 4'b1111, 2'd0, 1'b0);
        apply_stimulus(lanes4(13, 14, 15, 16), lanes4(10, 20, 30, 40), 4'b1111, 2'd0, 1'b0);

        $display("[TB] reset mid-stream");
        pulse_clear();
        apply_stimulus(lanes4(5, 5, 5, 5), lanes4(0, 0, 0, 0), 4'b0000, 2'd2, 1'b0);
        apply_stimulus(lanes4(5, 5, 5, 5), lanes4(0, 0, 0, 0), 4'b0000, 2'd2, 1'b0);
        bus.out_ready = 1'b0;
        @(negedge clk);
        check_output("pre_reset_valid", 64'(bus.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("reset_async_valid", 64'(bus.out_valid), 64'd0);
        check_output("reset_async_sum", 64'(bus.sum), 64'd0);
        sb.delete();
        for (int i = 0; i < L; i++) acc_m[i] = 0;
        @(posedge clk);
        #3;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_output("post_reset_ready", 64'(bus.in_ready), 64'd1);
        apply_stimulus(lanes4(5, 5, 5, 5), lanes4(0, 0, 0, 0), 4'b0000, 2'd2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_output("post_reset_acc", 64'(bus.sum[8:0]), 64'd15);

        for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
        check_output("drain_empty", 64'(sb.size()), 64'd0);
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
